// File: rtl/dbus_axi_bridge_pkg.sv
// Shared types for the DBus-to-AXI4-Lite bridge.
// DBUS_AXI_TIMEOUT_EN adds the DRAIN state used after a watchdog abort.
package dbus_axi_bridge_pkg;

  localparam int DEFAULT_AXI_ADDR_WIDTH = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
`ifdef DBUS_AXI_TIMEOUT_EN
    ,
    ST_DRAIN
`endif
  } dbus_axi_state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/dbus_axi_bridge_if.sv
// Core request port plus AXI4-Lite master channels of the bridge.
// master = bridge side, slave = core/interconnect side.
interface dbus_axi_bridge_if
  import dbus_axi_bridge_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH
);

  logic                      axi_rd_en;
  logic                      axi_wr_en;
  logic [AXI_ADDR_WIDTH-1:0] axi_addr;
  logic [31:0]               wr_data;
  logic [3:0]                wr_strobe;
  logic [31:0]               axi_rd_data;
  logic                      axi_access_fault;
  logic                      axi_busy;

  logic [AXI_ADDR_WIDTH-1:0] m_awaddr;
  logic                      m_awvalid;
  logic                      m_awready;
  logic [31:0]               m_wdata;
  logic [3:0]                m_wstrb;
  logic                      m_wvalid;
  logic                      m_wready;
  logic [1:0]                m_bresp;
  logic                      m_bvalid;
  logic                      m_bready;
  logic [AXI_ADDR_WIDTH-1:0] m_araddr;
  logic                      m_arvalid;
  logic                      m_arready;
  logic [31:0]               m_rdata;
  logic [1:0]                m_rresp;
  logic                      m_rvalid;
  logic                      m_rready;

  modport master (
    input  axi_rd_en, axi_wr_en, axi_addr,
    input  wr_data, wr_strobe,
    output axi_rd_data, axi_access_fault, axi_busy,
    output m_awaddr, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready,
    output m_araddr, m_arvalid,
    input  m_arready,
    input  m_rdata, m_rresp, m_rvalid,
    output m_rready
  );

  modport slave (
    output axi_rd_en, axi_wr_en, axi_addr,
    output wr_data, wr_strobe,
    input  axi_rd_data, axi_access_fault, axi_busy,
    input  m_awaddr, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready,
    input  m_araddr, m_arvalid,
    output m_arready,
    output m_rdata, m_rresp, m_rvalid,
    input  m_rready
  );

endinterface

// File: rtl/dbus_axi_bridge.sv
// Single-outstanding DBus request to AXI4-Lite transaction bridge.
// DBUS_AXI_TIMEOUT_EN enables the watchdog abort and DRAIN state.
module dbus_axi_bridge
  import dbus_axi_bridge_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = DEFAULT_AXI_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  dbus_axi_bridge_if.master    bus
);

  dbus_axi_state_t           state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               wdata_q;
  logic [3:0]                wstrb_q;
  logic [31:0]               rdata_q;
  logic                      fault_q;
  logic                      awvalid_q;
  logic                      wvalid_q;
  logic                      arvalid_q;
  logic                      bready_q;
  logic                      rready_q;

  logic req, busy;
  logic aw_fin, w_fin, ar_fin;
  logic b_hs, r_hs;

  assign req    = bus.axi_rd_en | bus.axi_wr_en;
  assign aw_fin = ~awvalid_q | bus.m_awready;
  assign w_fin  = ~wvalid_q | bus.m_wready;
  assign ar_fin = ~arvalid_q | bus.m_arready;
  assign b_hs   = bready_q & bus.m_bvalid;
  assign r_hs   = rready_q & bus.m_rvalid;

`ifdef DBUS_AXI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          to_q;
  logic          pend_q;
  logic          wr_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
`ifdef DBUS_AXI_TIMEOUT_EN
      cnt_q     <= '0;
      to_q      <= 1'b0;
      pend_q    <= 1'b0;
      wr_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.axi_wr_en) begin
            addr_q    <= bus.axi_addr;
            wdata_q   <= bus.wr_data;
            wstrb_q   <= bus.wr_strobe;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state_q   <= ST_WR_REQ;
          end else if (bus.axi_rd_en) begin
            addr_q    <= bus.axi_addr;
            arvalid_q <= 1'b1;
            state_q   <= ST_RD_REQ;
          end
`ifdef DBUS_AXI_TIMEOUT_EN
          cnt_q <= '0;
          wr_q  <= bus.axi_wr_en;
`endif
        end
        ST_WR_REQ: begin
          if (awvalid_q && bus.m_awready) awvalid_q <= 1'b0;
          if (wvalid_q && bus.m_wready) wvalid_q <= 1'b0;
          if (aw_fin && w_fin) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (b_hs) begin
            bready_q <= 1'b0;
            fault_q  <= resp_is_err(bus.m_bresp);
            state_q  <= ST_DONE;
          end
        end
        ST_RD_REQ: begin
          if (bus.m_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (r_hs) begin
            rready_q <= 1'b0;
            rdata_q  <= bus.m_rdata;
            fault_q  <= resp_is_err(bus.m_rresp);
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          fault_q <= 1'b0;
`ifdef DBUS_AXI_TIMEOUT_EN
          to_q    <= 1'b0;
          state_q <= to_q ? ST_DRAIN : ST_IDLE;
`else
          state_q <= ST_IDLE;
`endif
        end
`ifdef DBUS_AXI_TIMEOUT_EN
        ST_DRAIN: begin
          if (!pend_q || b_hs || r_hs) state_q <= ST_IDLE;
        end
`endif
        default: state_q <= ST_IDLE;
      endcase

`ifdef DBUS_AXI_TIMEOUT_EN
      if (state_q inside {ST_WR_REQ, ST_WR_RESP,
                          ST_RD_REQ, ST_RD_RESP}) begin
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CNT_LIM && !b_hs && !r_hs) begin
          fault_q <= 1'b1;
          to_q    <= 1'b1;
          pend_q  <= 1'b1;
          state_q <= ST_DONE;
        end
      end

      // Abandoned transaction is still finished on the bus, result dropped.
      if ((state_q == ST_DONE && to_q) || state_q == ST_DRAIN) begin
        if (awvalid_q && bus.m_awready) awvalid_q <= 1'b0;
        if (wvalid_q && bus.m_wready) wvalid_q <= 1'b0;
        if (arvalid_q && bus.m_arready) arvalid_q <= 1'b0;
        if (pend_q && wr_q && aw_fin && w_fin) bready_q <= 1'b1;
        if (pend_q && !wr_q && ar_fin) rready_q <= 1'b1;
        if (b_hs || r_hs) begin
          pend_q   <= 1'b0;
          bready_q <= 1'b0;
          rready_q <= 1'b0;
        end
      end
`endif
    end
  end

  always_comb begin
    busy = 1'b1;
    unique case (state_q)
      ST_IDLE:  busy = req;
      ST_DONE:  busy = 1'b0;
`ifdef DBUS_AXI_TIMEOUT_EN
      ST_DRAIN: busy = req;
`endif
      default:  busy = 1'b1;
    endcase
  end

  assign bus.axi_busy         = busy & ~rst;
  assign bus.axi_rd_data      = rdata_q;
  assign bus.axi_access_fault = fault_q;

  assign bus.m_awaddr  = addr_q;
  assign bus.m_awvalid = awvalid_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wstrb   = wstrb_q;
  assign bus.m_wvalid  = wvalid_q;
  assign bus.m_bready  = bready_q;
  assign bus.m_araddr  = addr_q;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_rready  = rready_q;

  logic unused_ok;
  assign unused_ok = ^{bus.m_bresp[0], bus.m_rresp[0],
                       TIMEOUT_CYCLES == 0};

endmodule
